// File: rtl/qoa_spi_slave.sv
`timescale 1ns/1ps
// qoa_spi_slave: SPI mode-0 slave front end for the QOA decoder.
// Oversamples sclk/cs_n/mosi in the sys_clk domain, deserialises MOSI bytes
// into rx_byte with a one-cycle data_rdy strobe, and shifts tx_byte out on MISO
// during the following byte transfer. Requires f_sys >= 8 * f_sclk.
// Reset is asserted asynchronously; its release is expected to be synchronised
// to sys_clk upstream.
// Optional build macro SPI_FRAME_ERR_EN enables the sticky frame_err flag;
// without it frame_err is tied low.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | cs_n high, MISO parked at IDLE_MISO, sclk edges ignored
// SHIFT  | inside a byte: sample MOSI on rise, advance MISO on fall
// RELOAD | byte complete, waiting for the fall that loads the next tx_byte
module qoa_spi_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       data_rdy,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   prev_sclk;
    logic                   prev_cs_n;

    logic sync_sclk;
    logic sync_cs_n;
    logic sync_mosi;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       miso_q, miso_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       byte_done_q, byte_done_d;
    logic       data_rdy_q;
    logic       busy_q;

    // Pin synchronisers plus one history flop per edge-detected pin.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            prev_sclk <= 1'b0;
            prev_cs_n <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            prev_sclk <= sync_sclk;
            prev_cs_n <= sync_cs_n;
        end
    end

    assign sync_sclk = sclk_sync[SYNC_STAGES-1];
    assign sync_cs_n = cs_sync[SYNC_STAGES-1];
    assign sync_mosi = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sync_sclk & ~prev_sclk;
    assign sclk_fall = ~sync_sclk & prev_sclk;
    assign cs_rise   = sync_cs_n & ~prev_cs_n;
    assign cs_fall   = ~sync_cs_n & prev_cs_n;

`ifdef SPI_FRAME_ERR_EN
    logic ferr_q, ferr_d;
`endif

    // State and datapath registers; data_rdy trails rx_byte by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            miso_q      <= IDLE_MISO;
            rx_byte_q   <= 8'h00;
            byte_done_q <= 1'b0;
            data_rdy_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            ferr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            rx_byte_q   <= rx_byte_d;
            byte_done_q <= byte_done_d;
            data_rdy_q  <= byte_done_q;
            busy_q      <= ~sync_cs_n;
`ifdef SPI_FRAME_ERR_EN
            ferr_q      <= ferr_d;
`endif
        end
    end

    // Next-state and datapath updates; a cs_n rise overrides any sclk edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        rx_byte_d   = rx_byte_q;
        byte_done_d = 1'b0;
`ifdef SPI_FRAME_ERR_EN
        ferr_d      = ferr_q;
`endif

        if (cs_rise) begin
`ifdef SPI_FRAME_ERR_EN
            if (bit_cnt_q != 3'd0) begin
                ferr_d = 1'b1;
            end
`endif
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = IDLE_MISO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                    miso_d    = IDLE_MISO;
                    if (cs_fall) begin
                        tx_shift_d = tx_byte;
                        miso_d     = tx_byte[7];
                        state_d    = ST_SHIFT;
`ifdef SPI_FRAME_ERR_EN
                        ferr_d     = 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], sync_mosi};
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d   = {rx_shift_q[6:0], sync_mosi};
                            byte_done_d = 1'b1;
                            bit_cnt_d   = 3'd0;
                            state_d     = ST_RELOAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[6];
                    end
                end
                ST_RELOAD: begin
                    if (sclk_fall) begin
                        tx_shift_d = tx_byte;
                        miso_d     = tx_byte[7];
                        state_d    = ST_SHIFT;
                    end else if (sclk_rise) begin
                        // Out-of-protocol rise: count it as bit 7 of the next byte.
                        rx_shift_d = {rx_shift_q[6:0], sync_mosi};
                        bit_cnt_d  = 3'd1;
                        tx_shift_d = tx_byte;
                        miso_d     = tx_byte[7];
                        state_d    = ST_SHIFT;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    miso_d    = IDLE_MISO;
                end
            endcase
        end
    end

    assign spi_miso = miso_q;
    assign rx_byte  = rx_byte_q;
    assign data_rdy = data_rdy_q;
    assign busy     = busy_q;
`ifdef SPI_FRAME_ERR_EN
    assign frame_err = ferr_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_qoa_spi_slave.sv
`timescale 1ns/1ps
// Directed bench for qoa_spi_slave: a timed SPI mode-0 host model drives the
// pins asynchronously to sys_clk (10 ns period); received bytes are logged by
// a negedge monitor and compared against hand-computed values.
module tb_qoa_spi_slave;

    localparam int   SYNC     = 2;
    localparam logic IDLE_LVL = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    localparam logic FERR_EXP = 1'b1;
`else
    localparam logic FERR_EXP = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       data_rdy;
    logic       busy;
    logic       frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         half     = 80;
    time        last_rise = 0;

    int         rdy_cnt  = 0;
    time        rdy_time = 0;
    logic [7:0] rx_log [0:1023];

    logic [7:0] tx_plan [0:255];
    int         plan_n   = 0;
    int         plan_dly = 0;

    qoa_spi_slave #(
        .SYNC_STAGES(SYNC),
        .IDLE_MISO  (IDLE_LVL)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .tx_byte  (tx_byte),
        .rx_byte  (rx_byte),
        .data_rdy (data_rdy),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Log every cycle data_rdy is high, away from the active edge.
    always @(negedge sys_clk) begin
        if (data_rdy === 1'b1) begin
            rx_log[rdy_cnt % 1024] <= rx_byte;
            rdy_cnt  <= rdy_cnt + 1;
            rdy_time <= $time;
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_start(input int phase);
        @(posedge sys_clk);
        #(phase);
        spi_cs_n = 1'b0;
        #(half);
    endtask

    task automatic frame_end();
        #(half);
        spi_cs_n = 1'b1;
        #(4 * half);
    endtask

    // Mode 0: MOSI set while sclk low, MISO sampled on the raw rising edge.
    task automatic xfer(input logic [7:0] d, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            spi_mosi = d[i];
            #(half);
            spi_sclk  = 1'b1;
            r[i]      = spi_miso;
            last_rise = $time;
            #(half);
            spi_sclk = 1'b0;
        end
    endtask

    // Background tx_byte updater: after each data_rdy wait plan_dly cycles,
    // then present the next planned byte, as the decoder would.
    task automatic start_tx_plan();
        fork
            begin
                for (int k = 0; k < plan_n; k++) begin
                    int budget;
                    budget = 2000;
                    @(negedge sys_clk);
                    while (data_rdy !== 1'b1 && budget > 0) begin
                        @(negedge sys_clk);
                        budget--;
                    end
                    repeat (plan_dly) @(negedge sys_clk);
                    tx_byte = tx_plan[k];
                end
            end
        join_none
    endtask

    initial begin
        logic [7:0] g0, g1, g2;
        logic [7:0] rxv [0:255];
        logic [7:0] txv [0:255];
        int base;
        int lat;
        int phase;

        sys_rst_n = 1'b0;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        tx_byte   = 8'h00;

        #1;
        chk("reset_rx_byte", rx_byte, 8'h00);
        chk("reset_data_rdy", data_rdy, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_miso", spi_miso, IDLE_LVL);

        #20;
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        repeat (5) @(posedge sys_clk);

        // Single byte 0x81, MISO returns 0xA5.
        tx_byte = 8'hA5;
        base = rdy_cnt;
        frame_start(3);
        chk("t1_busy_in_frame", busy, 1'b1);
        xfer(8'h81, 8, g0);
        frame_end();
        lat = int'((rdy_time - 5 - last_rise + 9) / 10);
        chk("t1_rdy_count", rdy_cnt - base, 1);
        chk("t1_rx_log", rx_log[base % 1024], 8'h81);
        chk("t1_rx_byte", rx_byte, 8'h81);
        chk("t1_miso_byte", g0, 8'hA5);
        chk("t1_latency", lat, SYNC + 2);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_miso_idle", spi_miso, IDLE_LVL);

        // Sample readback: 0x80, 0x00, 0x00; host reads 0xBE then 0xEF.
        tx_byte = 8'h00;
        tx_plan[0] = 8'hBE; tx_plan[1] = 8'hEF; tx_plan[2] = 8'h00;
        plan_n = 3; plan_dly = 3;
        start_tx_plan();
        base = rdy_cnt;
        frame_start(3);
        xfer(8'h80, 8, g0);
        xfer(8'h00, 8, g1);
        xfer(8'h00, 8, g2);
        frame_end();
        chk("t3_rdy_count", rdy_cnt - base, 3);
        chk("t3_rx0", rx_log[base % 1024], 8'h80);
        chk("t3_rx1", rx_log[(base + 1) % 1024], 8'h00);
        chk("t3_miso0", g0, 8'h00);
        chk("t3_miso1", g1, 8'hBE);
        chk("t3_miso2", g2, 8'hEF);

        // Three-byte frame 0x02, 0x12, 0x34; tx_byte becomes 0x5A.
        tx_byte = 8'h11;
        tx_plan[0] = 8'h5A; tx_plan[1] = 8'h5A; tx_plan[2] = 8'h5A;
        plan_n = 3; plan_dly = 3;
        start_tx_plan();
        base = rdy_cnt;
        frame_start(3);
        xfer(8'h02, 8, g0);
        xfer(8'h12, 8, g1);
        xfer(8'h34, 8, g2);
        frame_end();
        chk("t2_rdy_count", rdy_cnt - base, 3);
        chk("t2_rx0", rx_log[base % 1024], 8'h02);
        chk("t2_rx1", rx_log[(base + 1) % 1024], 8'h12);
        chk("t2_rx2", rx_log[(base + 2) % 1024], 8'h34);
        chk("t2_miso0", g0, 8'h11);
        chk("t2_miso1", g1, 8'h5A);
        chk("t2_miso2", g2, 8'h5A);

        // Abort after 5 bits of 0xFF, then a clean 0x33.
        tx_byte = 8'h00;
        base = rdy_cnt;
        frame_start(3);
        xfer(8'hFF, 5, g0);
        frame_end();
        chk("t4_abort_no_rdy", rdy_cnt - base, 0);
        chk("t4_abort_rx_kept", rx_byte, 8'h34);
        chk("t4_abort_frame_err", frame_err, FERR_EXP);
        chk("t4_abort_miso_idle", spi_miso, IDLE_LVL);
        base = rdy_cnt;
        frame_start(3);
        xfer(8'h33, 8, g0);
        frame_end();
        chk("t4_next_rdy_count", rdy_cnt - base, 1);
        chk("t4_next_rx", rx_byte, 8'h33);
        chk("t4_next_frame_err", frame_err, 1'b0);

        // Reset after 4 bits: outputs clear with no clock edge in between.
        tx_byte = 8'hFF;
        frame_start(3);
        xfer(8'hF0, 4, g0);
        #4;
        sys_rst_n = 1'b0;
        #1;
        chk("t5_rst_rx_byte", rx_byte, 8'h00);
        chk("t5_rst_data_rdy", data_rdy, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_frame_err", frame_err, 1'b0);
        chk("t5_rst_miso", spi_miso, IDLE_LVL);
        spi_cs_n = 1'b1;
        #100;
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        repeat (5) @(posedge sys_clk);
        tx_byte = 8'h3C;
        base = rdy_cnt;
        frame_start(3);
        xfer(8'hC3, 8, g0);
        frame_end();
        chk("t5_after_rdy_count", rdy_cnt - base, 1);
        chk("t5_after_rx", rx_byte, 8'hC3);
        chk("t5_after_miso", g0, 8'h3C);

        // f_sys = 8 * f_sclk, random phase, 256 back-to-back random bytes.
        half  = 40;
        phase = int'($urandom_range(1, 9));
        for (int k = 0; k < 256; k++) begin
            rxv[k] = 8'($urandom_range(0, 255));
            txv[k] = 8'($urandom_range(0, 255));
        end
        for (int k = 0; k < 255; k++) tx_plan[k] = txv[k + 1];
        tx_byte  = txv[0];
        plan_n   = 255;
        plan_dly = 0;
        start_tx_plan();
        base = rdy_cnt;
        frame_start(phase);
        for (int k = 0; k < 256; k++) begin
            xfer(rxv[k], 8, g0);
            chk($sformatf("t6_miso[%0d]", k), g0, txv[k]);
        end
        frame_end();
        chk("t6_rdy_count", rdy_cnt - base, 256);
        for (int k = 0; k < 256; k++) begin
            chk($sformatf("t6_rx[%0d]", k), rx_log[(base + k) % 1024], rxv[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
